// File: rtl/see_pkg.sv
// rtl/see_pkg.sv - shared state encoding and length-width constants for the weight streamer
package see_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } see_state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int LEN_W      = DEF_ADDR_W + 1;

    // Length counters need one extra bit so a full-depth stream (2^ADDR_W words) is expressible.
    function automatic int see_len_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/see_weight_fifo2.sv
// rtl/see_weight_fifo2.sv - two-entry fall-through skid FIFO between the weight RAM and the consumer
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drops all stored entries (stream abort)
//   in_valid/in_data  word arriving from the RAM output register this cycle
//   out_ready         consumer accepts out_data this cycle
//   out_valid/out_data head of FIFO, or the incoming word when the FIFO is empty
//   count             number of stored entries (0..2)
module see_weight_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       cnt;
    logic             pop_store;
    logic             push_store;

    // When empty the incoming word is presented directly so the RAM latency is not
    // lengthened by the FIFO; it is only stored if the consumer does not take it.
    assign out_valid  = (cnt != 2'd0) || in_valid;
    assign out_data   = (cnt != 2'd0) ? slot0 : in_data;
    assign pop_store  = out_ready && (cnt != 2'd0);
    assign push_store = in_valid && !((cnt == 2'd0) && out_ready);
    assign count      = cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt + {1'b0, push_store} - {1'b0, pop_store};
        end
    end

    // slot0 is always the head; a pop shifts slot1 down.
    always_ff @(posedge clk) begin
        if (pop_store) begin
            if (cnt == 2'd2) begin
                slot0 <= slot1;
            end
            if (push_store) begin
                if (cnt == 2'd1) begin
                    slot0 <= in_data;
                end else begin
                    slot1 <= in_data;
                end
            end
        end else if (push_store) begin
            if (cnt == 2'd0) begin
                slot0 <= in_data;
            end else begin
                slot1 <= in_data;
            end
        end
    end

endmodule

// File: rtl/see_weight_streamer.sv
// rtl/see_weight_streamer.sv - banked weight RAM with a flow-controlled sequential read streamer
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_start/i_base_addr/i_len    start a stream of i_len words from i_base_addr (wraps)
//   i_abort                      terminate the active stream without o_done
//   o_rd_data/o_valid/o_last     stream output, lane b at [b*DATA_W +: DATA_W]
//   i_ready                      consumer accepts o_rd_data
//   o_busy, o_done, o_err        stream active, normal-completion pulse, rejected-start pulse
//   i_wr_en/i_wr_bank_mask/i_wr_addr/i_wr_data  loader write port with per-lane enables
module see_weight_streamer
    import see_pkg::*;
#(
    parameter int    NUM_BANKS = 4,
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 10,
    parameter string MEM_FILE  = ""
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [ADDR_W-1:0]           i_base_addr,
    input  logic [ADDR_W:0]             i_len,
    input  logic                        i_abort,
    output logic [NUM_BANKS*DATA_W-1:0] o_rd_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    input  logic                        i_wr_en,
    input  logic [NUM_BANKS-1:0]        i_wr_bank_mask,
    input  logic [ADDR_W-1:0]           i_wr_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] i_wr_data
);

    localparam int LW     = see_len_w(ADDR_W);
    localparam int WORD_W = NUM_BANKS * DATA_W;

    see_state_t        state, state_n;
    logic [ADDR_W-1:0] rd_addr;
    logic [LW-1:0]     remaining;
    logic              inflight, inflight_last;
    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] mem_q;

    logic              f_valid;
    logic [WORD_W:0]   f_data;
    logic [1:0]        f_count;
    logic              pop, cap_ok, issue, accept, flush, done_n, err_n;
    logic              done_q, err_q;
    logic [2:0]        occ;

    // Read-first: the registered read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (issue) begin
            mem_q <= mem[rd_addr];
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (i_wr_en && i_wr_bank_mask[b]) begin
                mem[i_wr_addr][b*DATA_W +: DATA_W] <= i_wr_data[b*DATA_W +: DATA_W];
            end
        end
    end

    assign pop = f_valid && i_ready;
    // Words still owed to the consumer after this edge must leave room for one more read.
    assign occ    = {1'b0, f_count} + {2'b00, inflight};
    assign cap_ok = occ < (3'd2 + {2'b00, pop});

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        accept  = 1'b0;
        flush   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (i_abort) begin
                    flush   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    err_n = i_start;
                    if (cap_ok) begin
                        issue = 1'b1;
                        if (remaining == LW'(1)) begin
                            state_n = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    flush   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    err_n = i_start;
                    if (pop && f_data[WORD_W]) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rd_addr       <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_n;
            done_q        <= done_n;
            err_q         <= err_n;
            inflight      <= issue;
            inflight_last <= issue && (remaining == LW'(1));
            if (accept) begin
                rd_addr   <= i_base_addr;
                remaining <= i_len;
            end else if (issue) begin
                rd_addr   <= rd_addr + ADDR_W'(1);
                remaining <= remaining - LW'(1);
            end
        end
    end

    see_weight_fifo2 #(
        .WIDTH(WORD_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (inflight),
        .in_data  ({inflight_last, mem_q}),
        .out_ready(i_ready),
        .out_valid(f_valid),
        .out_data (f_data),
        .count    (f_count)
    );

    assign o_valid   = f_valid;
    assign o_rd_data = f_valid ? f_data[WORD_W-1:0] : '0;
    assign o_last    = f_valid && f_data[WORD_W];
    assign o_busy    = (state != ST_IDLE);
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_see_weight_streamer.sv
// tb/tb_see_weight_streamer.sv - self-checking bench for see_weight_streamer
module tb_see_weight_streamer;

    localparam int NB    = 4;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int WW    = NB * DW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_len;
    logic          i_abort;
    logic [WW-1:0] o_rd_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic          i_wr_en;
    logic [NB-1:0] i_wr_bank_mask;
    logic [AW-1:0] i_wr_addr;
    logic [WW-1:0] i_wr_data;

    always #5 clk = ~clk;

    see_weight_streamer #(
        .NUM_BANKS(NB),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MEM_FILE ("")
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_len         (i_len),
        .i_abort       (i_abort),
        .o_rd_data     (o_rd_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .i_wr_en       (i_wr_en),
        .i_wr_bank_mask(i_wr_bank_mask),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data)
    );

    logic [WW-1:0] mem_m [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] formula_word(input int addr);
        logic [WW-1:0] w;
        for (int b = 0; b < NB; b++) w[b*DW +: DW] = 32'(16 * addr + b);
        return w;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int b = 0; b < NB; b++) w[b*DW +: DW] = $urandom;
        return w;
    endfunction

    task automatic model_write(input int addr, input logic [NB-1:0] mask, input logic [WW-1:0] data);
        for (int b = 0; b < NB; b++)
            if (mask[b]) mem_m[addr][b*DW +: DW] = data[b*DW +: DW];
    endtask

    task automatic write_word(input int addr, input logic [NB-1:0] mask, input logic [WW-1:0] data);
        i_wr_en = 1'b1; i_wr_addr = AW'(addr); i_wr_bank_mask = mask; i_wr_data = data;
        @(negedge clk);
        i_wr_en = 1'b0;
        model_write(addr, mask, data);
    endtask

    // Cycle 0 is the cycle i_start is driven; every call begins and ends on a falling edge.
    task automatic run_stream(input int base, input int len, input int rmode, input int err_at,
                              input int wr_at, input int wr_addr, input logic [NB-1:0] wr_mask,
                              input logic [WW-1:0] wr_data);
        logic [WW-1:0] exp_q[$];
        logic [WW-1:0] prev_data;
        logic          prev_last, prev_stall;
        int            cyc, hs, first_v, last_hs, done_cyc, p;
        for (int i = 0; i < len; i++) exp_q.push_back(mem_m[(base + i) % DEPTH]);
        i_start = 1'b1; i_base_addr = AW'(base); i_len = (AW+1)'(len); i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1; hs = 0; first_v = -1; last_hs = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (done_cyc < 0 && cyc < 300) begin
            p = cyc - 2;
            case (rmode)
                0: i_ready = 1'b1;
                1: i_ready = (p >= 0 && p < 4) ? (p == 0 || p == 3) : 1'($urandom_range(0, 1));
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            i_start = (cyc == err_at);
            if (cyc == err_at) begin
                i_base_addr = AW'($urandom); i_len = (AW+1)'(5);
            end
            i_wr_en = (cyc == wr_at);
            if (cyc == wr_at) begin
                i_wr_addr = AW'(wr_addr); i_wr_bank_mask = wr_mask; i_wr_data = wr_data;
                model_write(wr_addr, wr_mask, wr_data);
            end
            if (prev_stall) begin
                check("stall_valid", o_valid, 1'b1);
                check("stall_data", o_rd_data, prev_data);
                check("stall_last", o_last, prev_last);
            end
            check("err_pulse", o_err, (err_at > 0 && cyc == err_at + 1));
            check("busy", o_busy, (last_hs < 0));
            if (o_valid && first_v < 0) first_v = cyc;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", hs + 1, len);
                end else begin
                    check("data", o_rd_data, exp_q[0]);
                    check("last", o_last, (exp_q.size() == 1));
                    if (exp_q.size() == 1) last_hs = cyc;
                    void'(exp_q.pop_front());
                end
                hs++;
            end
            if (o_done) begin
                check("done_cycle", cyc, last_hs + 1);
                done_cyc = cyc;
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_rd_data;
            prev_last  = o_last;
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0; i_wr_en = 1'b0; i_ready = 1'b1;
        check("handshakes", hs, len);
        check("done_seen", (done_cyc > 0), 1'b1);
        if (rmode == 0) begin
            check("first_valid", first_v, 2);
            check("n_plus_1", last_hs, len + 1);
        end
        check("idle_valid", o_valid, 1'b0);
        check("idle_busy", o_busy, 1'b0);
        check("done_width", o_done, 1'b0);
    endtask

    // Terminates a stream after 'after_n' handshakes, by i_abort (with a colliding i_start) or rst.
    task automatic run_abort(input int base, input int len, input int after_n, input bit use_rst);
        logic [WW-1:0] exp_q[$];
        int            cyc, hs;
        for (int i = 0; i < len; i++) exp_q.push_back(mem_m[(base + i) % DEPTH]);
        i_start = 1'b1; i_base_addr = AW'(base); i_len = (AW+1)'(len); i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1; hs = 0;
        while (hs < after_n && cyc < 50) begin
            if (o_valid && i_ready) begin
                check("abort_data", o_rd_data, exp_q[0]);
                void'(exp_q.pop_front());
                hs++;
            end
            if (hs < after_n) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("abort_reached", hs, after_n);
        if (use_rst) begin
            rst = 1'b1;
        end else begin
            i_abort = 1'b1; i_start = 1'b1; i_len = (AW+1)'(3);
        end
        @(negedge clk);
        rst = 1'b0; i_abort = 1'b0; i_start = 1'b0;
        check("term_valid", o_valid, 1'b0);
        check("term_busy", o_busy, 1'b0);
        check("term_err", o_err, 1'b0);
        check("term_data", o_rd_data, '0);
        for (int k = 0; k < 6; k++) begin
            check("term_no_done", o_done, 1'b0);
            check("term_stay_idle", o_valid | o_busy, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_abort = 1'b0;
        i_ready = 1'b1; i_wr_en = 1'b0; i_wr_bank_mask = '0; i_wr_addr = '0; i_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_last", o_last, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_data", o_rd_data, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 8; a++) write_word(a, 4'hF, formula_word(a));
        for (int a = 8; a < 48; a++) write_word(a, 4'hF, rand_word());
        for (int a = 1016; a < 1024; a++) write_word(a, 4'hF, formula_word(a));
        for (int k = 0; k < 12; k++) write_word($urandom_range(8, 47), 4'($urandom), rand_word());

        run_stream(2, 4, 0, 0, 0, 0, '0, '0);
        run_stream(1022, 4, 0, 0, 0, 0, '0, '0);
        run_stream($urandom_range(0, 30), 6, 1, 0, 0, 0, '0, '0);
        run_stream($urandom_range(0, 30), 6, 2, 0, 0, 0, '0, '0);

        run_stream(0, 6, 0, 3, 0, 0, '0, '0);
        i_start = 1'b1; i_base_addr = AW'(5); i_len = '0;
        @(negedge clk);
        i_start = 1'b0;
        check("len0_done", o_done, 1'b1);
        check("len0_valid", o_valid, 1'b0);
        check("len0_busy", o_busy, 1'b0);
        @(negedge clk);
        check("len0_done_width", o_done, 1'b0);
        check("len0_valid2", o_valid, 1'b0);

        run_stream(2, 4, 0, 0, 2, 3, 4'b0101, rand_word());
        run_stream(2, 4, 0, 0, 0, 0, '0, '0);

        run_abort(0, 8, 2, 1'b0);
        run_stream(5, 5, 0, 0, 0, 0, '0, '0);
        run_abort(10, 8, 3, 1'b1);
        run_stream(5, 5, 2, 0, 0, 0, '0, '0);

        for (int k = 0; k < 6; k++)
            run_stream($urandom_range(0, 30), $urandom_range(1, 10), 2, 0, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++)
            run_stream($urandom_range(1016, 1023), $urandom_range(1, 20), 2, 0, 0, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/see_weight_streamer.md
SEE_WEIGHT_STREAMER -- requirements
Module: see_weight_streamer

Interface
REQ-001 Parameter NUM_BANKS, default 4, meaning one weight lane per PE, each lane read in parallel.
REQ-002 Parameter DATA_W, default 32, meaning signed weight width per lane.
REQ-003 Parameter ADDR_W, default 10, meaning word address width, depth 2^ADDR_W per bank.
REQ-004 Parameter MEM_FILE, default "", meaning hex image of NUM_BANKS*DATA_W-bit words, lane b at bits [b*DATA_W +: DATA_W]; not loaded when empty.
REQ-005 Port clk  in  1  sole clock, all logic on rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port i_start  in  1  start stream request (one-cycle pulse).
REQ-008 Port i_base_addr  in  ADDR_W  first word address of stream.
REQ-009 Port i_len  in  ADDR_W+1  number of words to stream.
REQ-010 Port i_abort  in  1  terminate active stream.
REQ-011 Port o_rd_data  out  NUM_BANKS*DATA_W  signed lane words, lane b at [b*DATA_W +: DATA_W].
REQ-012 Port o_valid  out  1  o_rd_data valid.
REQ-013 Port i_ready  in  1  consumer accepts o_rd_data.
REQ-014 Port o_last  out  1  current valid word is final word of stream.
REQ-015 Port o_busy  out  1  stream active.
REQ-016 Port o_done  out  1  one-cycle pulse, stream completed normally.
REQ-017 Port o_err  out  1  one-cycle pulse, i_start rejected.
REQ-018 Port i_wr_en, i_wr_bank_mask, i_wr_addr, i_wr_data  in  1, NUM_BANKS, ADDR_W, NUM_BANKS*DATA_W  loader write; lane b written when i_wr_en and mask[b].

Function
REQ-019 FSM states IDLE, STREAM, DRAIN; IDLE->STREAM on i_start with i_len!=0; STREAM->DRAIN after final read issued; DRAIN->IDLE on handshake (o_valid&i_ready) of final word.
REQ-020 i_start in IDLE with i_len==0 shall pulse o_done next cycle, stay IDLE.
REQ-021 i_start while o_busy shall be ignored and pulse o_err next cycle.
REQ-022 Read address shall start at i_base_addr, increment by 1 per issued read, wrap modulo 2^ADDR_W.
REQ-023 Memory read latency 1 cycle; output via 2-entry skid FIFO; first o_valid 2 cycles after accepted i_start when i_ready high.
REQ-024 Read issued only when FIFO count + in-flight reads - (pop this cycle) < 2; no word dropped or duplicated under any i_ready pattern.
REQ-025 With i_ready held high, throughput shall be 1 word/cycle, N words in N+1 cycles after start.
REQ-026 o_valid, o_rd_data, o_last shall hold stable while o_valid & !i_ready.
REQ-027 o_done shall pulse the cycle after the final-word handshake; o_busy high from cycle after accepted start until that cycle.
REQ-028 i_abort in STREAM/DRAIN shall return to IDLE next cycle, flush FIFO and in-flight read, drop o_valid, no o_done; ignored in IDLE; abort with simultaneous i_start: abort wins, start ignored, no o_err.
REQ-029 Writes accepted in any state, 1 write/cycle; read and write to same bank/address same cycle shall return old data (read-first).
REQ-030 Unmasked lanes unchanged on write.

Reset
REQ-031 rst shall force IDLE, empty FIFO, cancel in-flight reads, o_valid/o_last/o_busy/o_done/o_err=0, o_rd_data=0; memory contents retained; rst mid-stream gives no o_done.

Structure
REQ-032 State encoding and LEN_W=ADDR_W+1 constant shall live in shared package see_pkg.
REQ-033 One sub-module see_weight_fifo2 (2-entry skid FIFO, parameter WIDTH) shall be instantiated; memory shall be one block-RAM array with per-lane write enables.

Verification
REQ-034 Load addr 0..7 lane b = 16*addr+b, start base=2 len=4, i_ready=1 -> words addr 2..5 on consecutive cycles, o_last on addr 5, o_done next cycle.
REQ-035 Base=1022 len=4 (ADDR_W=10) -> addresses 1022,1023,0,1 in order.
REQ-036 len=6, i_ready toggling 1,0,0,1,... random -> exactly 6 handshakes, data stable during stalls, no loss/duplication.
REQ-037 Start while busy -> o_err pulse, stream unaffected; len=0 start -> o_done pulse, o_valid never high.
REQ-038 Write addr 3 mask 0101 same cycle as read of addr 3 -> old value streamed; later re-read shows lanes 0,2 updated, lanes 1,3 unchanged.
REQ-039 i_abort after 2 of 8 words, and rst mid-stream -> o_valid low next cycle, no o_done, new start then streams correctly.
